// File: rtl/mc_sequencer_if.sv
// Bus between the multicycle sequencer and its surroundings: the instruction
// register and memory handshake come in, and datapath controls go out.
// Optional macro: MC_ILLEGAL_TRAP_EN adds the 'illegal' status signal.
//   master : instruction register / memory side (drives run, opcode, funct, mem_ready)
//   slave  : mc_sequencer (drives all controls, alu_ctrl, state, instr_done, mem_err)
interface mc_sequencer_if;
    logic       run;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;

    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemToReg;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic [1:0] PCSource;
    logic [1:0] ALUSrcB;
    logic [2:0] alu_ctrl;
    logic [3:0] state;
    logic       instr_done;
    logic       mem_err;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegal;

    modport master (
        output run, opcode, funct, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
               ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, alu_ctrl, state,
               instr_done, mem_err, illegal
    );
    modport slave (
        input  run, opcode, funct, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
               ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, alu_ctrl, state,
               instr_done, mem_err, illegal
    );
`else
    modport master (
        output run, opcode, funct, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
               ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, alu_ctrl, state,
               instr_done, mem_err
    );
    modport slave (
        input  run, opcode, funct, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
               ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, alu_ctrl, state,
               instr_done, mem_err
    );
`endif
endinterface

// File: rtl/mc_sequencer.sv
// Multicycle MIPS sequencer: owns the 4-bit state register and decodes
// state/opcode/funct into datapath controls, with a memory wait-state
// handshake, run/halt gate, wait-timeout watchdog and ALU function control.
// Optional macro: MC_ILLEGAL_TRAP_EN -- unknown opcodes trap in state 4'hF
// (bus.illegal=1) instead of being retired as a NOP.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset; forces every output to 0 while low
//   bus   : mc_sequencer_if.slave (run/opcode/funct/mem_ready in, controls out)
// Outputs are combinational decodes of the state register (and mem_ready),
// because IRWrite/PCWrite/instr_done must react in the same cycle as mem_ready.
module mc_sequencer #(
    parameter int unsigned WAIT_LIMIT = 0,
    parameter int unsigned CNT_W      = 8
) (
    input logic           clk,
    input logic           rst_n,
    mc_sequencer_if.slave bus
);
    localparam logic [3:0] FETCH  = 4'h0;
    localparam logic [3:0] DECODE = 4'h1;
    localparam logic [3:0] MEMADR = 4'h2;
    localparam logic [3:0] MEMRD  = 4'h3;
    localparam logic [3:0] MEMWB  = 4'h4;
    localparam logic [3:0] MEMWR  = 4'h5;
    localparam logic [3:0] EXEC   = 4'h6;
    localparam logic [3:0] RWB    = 4'h7;
    localparam logic [3:0] BEQ    = 4'h8;
    localparam logic [3:0] JUMP   = 4'h9;
`ifdef MC_ILLEGAL_TRAP_EN
    localparam logic [3:0] TRAP   = 4'hF;
`endif

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Counter value on which the next idle wait cycle hits the limit.
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

    logic [3:0]       stateQ, stateNext;
    logic [CNT_W-1:0] waitCnt, cntNext;
    logic             waiting, timeout;

    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, aluSrcA, regWrite, regDst, instrDone, memErr;
    logic [1:0] pcSource, aluSrcB;
    logic [2:0] aluCtrl;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegalC;
`endif

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ  <= FETCH;
            waitCnt <= '0;
        end else begin
            stateQ  <= stateNext;
            waitCnt <= cntNext;
        end
    end

    // Watchdog: counts consecutive not-ready cycles in the memory wait states.
    always_comb begin
        waiting = ((stateQ == FETCH) && bus.run) || (stateQ == MEMRD) || (stateQ == MEMWR);
        timeout = (WAIT_LIMIT > 0) && waiting && !bus.mem_ready && (waitCnt == LIMIT_M1);
        cntNext = (waiting && !bus.mem_ready && !timeout) ? waitCnt + CNT_W'(1) : '0;
    end

    // Next-state and control decode.
    always_comb begin
        stateNext   = stateQ;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        aluSrcA     = 1'b0;
        regWrite    = 1'b0;
        regDst      = 1'b0;
        pcSource    = 2'b00;
        aluSrcB     = 2'b00;
        aluCtrl     = 3'b000;
        instrDone   = 1'b0;
        memErr      = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
        illegalC    = 1'b0;
`endif
        case (stateQ)
            FETCH: begin
                if (bus.run) begin
                    memRead = 1'b1;
                    aluSrcB = 2'b01;
                    aluCtrl = ALU_ADD;
                    if (timeout) begin
                        memErr = 1'b1;
                    end else if (bus.mem_ready) begin
                        irWrite   = 1'b1;
                        pcWrite   = 1'b1;
                        stateNext = DECODE;
                    end
                end
            end
            DECODE: begin
                aluSrcB = 2'b11;
                aluCtrl = ALU_ADD;
                case (bus.opcode)
                    OP_RTYPE:     stateNext = EXEC;
                    OP_LW, OP_SW: stateNext = MEMADR;
                    OP_BEQ:       stateNext = BEQ;
                    OP_J:         stateNext = JUMP;
                    default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                        stateNext = TRAP;
`else
                        stateNext = FETCH;
                        instrDone = 1'b1;
`endif
                    end
                endcase
            end
            MEMADR: begin
                aluSrcA   = 1'b1;
                aluSrcB   = 2'b10;
                aluCtrl   = ALU_ADD;
                stateNext = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
                if (timeout) begin
                    memErr    = 1'b1;
                    stateNext = FETCH;
                end else if (bus.mem_ready) begin
                    stateNext = MEMWB;
                end
            end
            MEMWB: begin
                regWrite  = 1'b1;
                memToReg  = 1'b1;
                instrDone = 1'b1;
                stateNext = FETCH;
            end
            MEMWR: begin
                iorD = 1'b1;
                // On timeout the write strobe is withdrawn so memory never commits.
                if (timeout) begin
                    memErr    = 1'b1;
                    stateNext = FETCH;
                end else begin
                    memWrite = 1'b1;
                    if (bus.mem_ready) begin
                        instrDone = 1'b1;
                        stateNext = FETCH;
                    end
                end
            end
            EXEC: begin
                aluSrcA   = 1'b1;
                stateNext = RWB;
                case (bus.funct)
                    6'b100000: aluCtrl = ALU_ADD;
                    6'b100010: aluCtrl = ALU_SUB;
                    6'b100100: aluCtrl = ALU_AND;
                    6'b100101: aluCtrl = ALU_OR;
                    6'b101010: aluCtrl = ALU_SLT;
                    default:   aluCtrl = ALU_ADD;
                endcase
            end
            RWB: begin
                regWrite  = 1'b1;
                regDst    = 1'b1;
                instrDone = 1'b1;
                stateNext = FETCH;
            end
            BEQ: begin
                aluSrcA     = 1'b1;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
                aluCtrl     = ALU_SUB;
                instrDone   = 1'b1;
                stateNext   = FETCH;
            end
            JUMP: begin
                pcWrite   = 1'b1;
                pcSource  = 2'b10;
                instrDone = 1'b1;
                stateNext = FETCH;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            TRAP: begin
                illegalC  = 1'b1;
                stateNext = TRAP;
            end
`endif
            default: stateNext = FETCH;
        endcase
    end

    // Reset forces every output low regardless of state.
    assign bus.PCWrite     = rst_n & pcWrite;
    assign bus.PCWriteCond = rst_n & pcWriteCond;
    assign bus.IorD        = rst_n & iorD;
    assign bus.MemRead     = rst_n & memRead;
    assign bus.MemWrite    = rst_n & memWrite;
    assign bus.IRWrite     = rst_n & irWrite;
    assign bus.MemToReg    = rst_n & memToReg;
    assign bus.ALUSrcA     = rst_n & aluSrcA;
    assign bus.RegWrite    = rst_n & regWrite;
    assign bus.RegDst      = rst_n & regDst;
    assign bus.PCSource    = rst_n ? pcSource : 2'b00;
    assign bus.ALUSrcB     = rst_n ? aluSrcB  : 2'b00;
    assign bus.alu_ctrl    = rst_n ? aluCtrl  : 3'b000;
    assign bus.state       = rst_n ? stateQ   : 4'h0;
    assign bus.instr_done  = rst_n & instrDone;
    assign bus.mem_err     = rst_n & memErr;
`ifdef MC_ILLEGAL_TRAP_EN
    assign bus.illegal     = rst_n & illegalC;
`endif
endmodule

// File: tb/tb_mc_sequencer.sv
// Directed, table-driven bench for mc_sequencer (instance built with WAIT_LIMIT=4).
// Each table row is one clock cycle: inputs are driven after the falling edge
// and outputs compared 1 time unit later, before the next rising edge.
module tb_mc_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_sequencer_if bus();

    mc_sequencer #(.WAIT_LIMIT(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Write-enable/select flags packed as
    // {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, ALUSrcA, RegWrite, RegDst}
    typedef struct {
        logic       rstN;
        logic       run;
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        logic [3:0] st;
        logic [9:0] w;
        logic [1:0] pcs;
        logic [1:0] srcb;
        logic [2:0] alu;
        logic       done;
        logic       err;
    } vec_t;

    vec_t tbl[$];
    int   nChecks = 0;
    int   nFails  = 0;

    function automatic vec_t mk(logic rstN, logic run, logic [5:0] op, logic [5:0] fn, logic rdy,
                                logic [3:0] st, logic [9:0] w, logic [1:0] pcs, logic [1:0] srcb,
                                logic [2:0] alu, logic done, logic err);
        vec_t v;
        v.rstN = rstN; v.run = run; v.op = op; v.fn = fn; v.rdy = rdy;
        v.st = st; v.w = w; v.pcs = pcs; v.srcb = srcb; v.alu = alu; v.done = done; v.err = err;
        return v;
    endfunction

    // FETCH completing with mem_ready=1: MemRead, IRWrite, PCWrite, PC+4.
    function automatic vec_t fetchRow(logic [5:0] op, logic [5:0] fn);
        return mk(1, 1, op, fn, 1, 4'h0, 10'b1001010000, 2'b00, 2'b01, 3'b010, 0, 0);
    endfunction

    function automatic vec_t decodeRow(logic [5:0] op, logic [5:0] fn, logic done);
        return mk(1, 1, op, fn, 1, 4'h1, 10'b0000000000, 2'b00, 2'b11, 3'b010, done, 0);
    endfunction

    function automatic vec_t memadrRow(logic [5:0] op);
        return mk(1, 1, op, 6'h00, 1, 4'h2, 10'b0000000100, 2'b00, 2'b10, 3'b010, 0, 0);
    endfunction

    function automatic vec_t execRow(logic [5:0] fn, logic [2:0] alu);
        return mk(1, 1, 6'h00, fn, 1, 4'h6, 10'b0000000100, 2'b00, 2'b00, alu, 0, 0);
    endfunction

    function automatic vec_t rwbRow(logic [5:0] fn);
        return mk(1, 1, 6'h00, fn, 1, 4'h7, 10'b0000000011, 2'b00, 2'b00, 3'b000, 1, 0);
    endfunction

    task automatic drive(input vec_t v);
        rst_n         = v.rstN;
        bus.run       = v.run;
        bus.opcode    = v.op;
        bus.funct     = v.fn;
        bus.mem_ready = v.rdy;
    endtask

    task automatic checkRow(input vec_t v, input string tag);
        logic [9:0] w;
        w = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
             bus.IRWrite, bus.MemToReg, bus.ALUSrcA, bus.RegWrite, bus.RegDst};
        nChecks++;
        if (bus.state !== v.st || w !== v.w || bus.PCSource !== v.pcs || bus.ALUSrcB !== v.srcb ||
            bus.alu_ctrl !== v.alu || bus.instr_done !== v.done || bus.mem_err !== v.err) begin
            nFails++;
            $display("FAIL %s: got st=%h w=%b pcs=%b srcb=%b alu=%b done=%b err=%b, expected st=%h w=%b pcs=%b srcb=%b alu=%b done=%b err=%b",
                     tag, bus.state, w, bus.PCSource, bus.ALUSrcB, bus.alu_ctrl, bus.instr_done, bus.mem_err,
                     v.st, v.w, v.pcs, v.srcb, v.alu, v.done, v.err);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        #1;
        checkRow(v, tag);
    endtask

    task automatic checkBit(input logic act, input logic exp, input string tag);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %b, expected %b", tag, act, exp);
        end
    endtask

    initial begin
        vec_t zeroRow;
        vec_t v;

        // Reset: everything forced low.
        tbl.push_back(mk(0, 1, 6'h00, 6'h00, 1, 4'h0, 10'b0, 2'b00, 2'b00, 3'b000, 0, 0));
        // lw, memory always ready: 0,1,2,3,4.
        tbl.push_back(fetchRow(6'h23, 6'h00));
        tbl.push_back(decodeRow(6'h23, 6'h00, 0));
        tbl.push_back(memadrRow(6'h23));
        tbl.push_back(mk(1, 1, 6'h23, 6'h00, 1, 4'h3, 10'b0011000000, 2'b00, 2'b00, 3'b000, 0, 0));
        tbl.push_back(mk(1, 1, 6'h23, 6'h00, 1, 4'h4, 10'b0000001010, 2'b00, 2'b00, 3'b000, 1, 0));
        // add: 0,1,6,7.
        tbl.push_back(fetchRow(6'h00, 6'h20));
        tbl.push_back(decodeRow(6'h00, 6'h20, 0));
        tbl.push_back(execRow(6'h20, 3'b010));
        tbl.push_back(rwbRow(6'h20));
        // FETCH stalled 3 cycles, then beq.
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 1, 6'h04, 6'h00, 0, 4'h0, 10'b0001000000, 2'b00, 2'b01, 3'b010, 0, 0));
        tbl.push_back(fetchRow(6'h04, 6'h00));
        tbl.push_back(decodeRow(6'h04, 6'h00, 0));
        tbl.push_back(mk(1, 1, 6'h04, 6'h00, 1, 4'h8, 10'b0100000100, 2'b01, 2'b00, 3'b110, 1, 0));
        // j.
        tbl.push_back(fetchRow(6'h02, 6'h00));
        tbl.push_back(decodeRow(6'h02, 6'h00, 0));
        tbl.push_back(mk(1, 1, 6'h02, 6'h00, 1, 4'h9, 10'b1000000000, 2'b10, 2'b00, 3'b000, 1, 0));
        // sub, slt, or, and, unknown funct.
        tbl.push_back(fetchRow(6'h00, 6'h22));
        tbl.push_back(decodeRow(6'h00, 6'h22, 0));
        tbl.push_back(execRow(6'h22, 3'b110));
        tbl.push_back(rwbRow(6'h22));
        tbl.push_back(fetchRow(6'h00, 6'h2A));
        tbl.push_back(decodeRow(6'h00, 6'h2A, 0));
        tbl.push_back(execRow(6'h2A, 3'b111));
        tbl.push_back(rwbRow(6'h2A));
        tbl.push_back(fetchRow(6'h00, 6'h25));
        tbl.push_back(decodeRow(6'h00, 6'h25, 0));
        tbl.push_back(execRow(6'h25, 3'b001));
        tbl.push_back(rwbRow(6'h25));
        tbl.push_back(fetchRow(6'h00, 6'h24));
        tbl.push_back(decodeRow(6'h00, 6'h24, 0));
        tbl.push_back(execRow(6'h24, 3'b000));
        tbl.push_back(rwbRow(6'h24));
        tbl.push_back(fetchRow(6'h00, 6'h3F));
        tbl.push_back(decodeRow(6'h00, 6'h3F, 0));
        tbl.push_back(execRow(6'h3F, 3'b010));
        tbl.push_back(rwbRow(6'h3F));
        // sw never acknowledged: 4 cycles in MEMWR, the 4th aborts with mem_err and no MemWrite.
        tbl.push_back(fetchRow(6'h2B, 6'h00));
        tbl.push_back(decodeRow(6'h2B, 6'h00, 0));
        tbl.push_back(memadrRow(6'h2B));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 1, 6'h2B, 6'h00, 0, 4'h5, 10'b0010100000, 2'b00, 2'b00, 3'b000, 0, 0));
        tbl.push_back(mk(1, 1, 6'h2B, 6'h00, 0, 4'h5, 10'b0010000000, 2'b00, 2'b00, 3'b000, 0, 1));
        // sw acknowledged after one wait cycle.
        tbl.push_back(fetchRow(6'h2B, 6'h00));
        tbl.push_back(decodeRow(6'h2B, 6'h00, 0));
        tbl.push_back(memadrRow(6'h2B));
        tbl.push_back(mk(1, 1, 6'h2B, 6'h00, 0, 4'h5, 10'b0010100000, 2'b00, 2'b00, 3'b000, 0, 0));
        tbl.push_back(mk(1, 1, 6'h2B, 6'h00, 1, 4'h5, 10'b0010100000, 2'b00, 2'b00, 3'b000, 1, 0));
        // Reset in the middle of a stalled MEMRD.
        tbl.push_back(fetchRow(6'h23, 6'h00));
        tbl.push_back(decodeRow(6'h23, 6'h00, 0));
        tbl.push_back(memadrRow(6'h23));
        tbl.push_back(mk(1, 1, 6'h23, 6'h00, 0, 4'h3, 10'b0011000000, 2'b00, 2'b00, 3'b000, 0, 0));
        tbl.push_back(mk(0, 1, 6'h23, 6'h00, 1, 4'h0, 10'b0, 2'b00, 2'b00, 3'b000, 0, 0));
        tbl.push_back(mk(1, 1, 6'h23, 6'h00, 0, 4'h0, 10'b0001000000, 2'b00, 2'b01, 3'b010, 0, 0));
        // Halted: FETCH holds with every control low, mem_ready ignored.
        tbl.push_back(mk(1, 0, 6'h23, 6'h00, 1, 4'h0, 10'b0, 2'b00, 2'b00, 3'b000, 0, 0));
        tbl.push_back(mk(1, 0, 6'h23, 6'h00, 1, 4'h0, 10'b0, 2'b00, 2'b00, 3'b000, 0, 0));

        bus.run = 1'b0; bus.opcode = '0; bus.funct = '0; bus.mem_ready = 1'b0;

        foreach (tbl[i]) step(tbl[i], $sformatf("row%0d", i));

        // Unknown opcode 6'h3F.
        zeroRow = mk(1, 1, 6'h3F, 6'h00, 1, 4'h0, 10'b0, 2'b00, 2'b00, 3'b000, 0, 0);
        step(fetchRow(6'h3F, 6'h00), "illegal_fetch");
`ifdef MC_ILLEGAL_TRAP_EN
        step(decodeRow(6'h3F, 6'h00, 0), "illegal_decode");
        v = zeroRow; v.st = 4'hF;
        step(v, "trap_hold0");
        checkBit(bus.illegal, 1'b1, "illegal_flag0");
        step(v, "trap_hold1");
        checkBit(bus.illegal, 1'b1, "illegal_flag1");
        v = zeroRow; v.rstN = 1'b0;
        step(v, "trap_reset");
        checkBit(bus.illegal, 1'b0, "illegal_in_reset");
        v = zeroRow; v.run = 1'b0;
        step(v, "after_trap_reset");
        checkBit(bus.illegal, 1'b0, "illegal_cleared");
`else
        step(decodeRow(6'h3F, 6'h00, 1), "nop_decode");
        v = zeroRow; v.run = 1'b0;
        step(v, "nop_back_to_fetch");
        step(fetchRow(6'h00, 6'h20), "nop_next_fetch");
        checkBit(bus.state == 4'hF, 1'b0, "no_trap_state");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
